// File: rtl/arith_pkg.sv
// Shared arithmetic package.
// Holds the FSM state encoding used by the bit-serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// 1-bit full subtractor: computes x - y - b_in.
// It is built from two half-subtractors and an OR, the same way the full adder is.
// Ports:
//   x, y   : operand bits (minuend, subtrahend)
//   b_in   : incoming borrow
//   d      : difference bit
//   b_out  : outgoing borrow
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    logic d1, b1, b2;

    // first half-subtractor: x - y
    assign d1 = x ^ y;
    assign b1 = ~x & y;

    // second half-subtractor: d1 - b_in
    assign d  = d1 ^ b_in;
    assign b2 = ~d1 & b_in;

    assign b_out = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// A start/done handshake accepts operands in IDLE or in the DONE cycle, so
// operations can run back-to-back at one result per WIDTH+1 cycles.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   start        : request; sampled only in IDLE or DONE
//   a, b         : minuend / subtrahend, captured on the accepting edge
//   busy         : high while bits are being processed
//   done         : one-cycle pulse when results update
//   diff         : a - b mod 2^WIDTH, held until the next completion
//   borrow_out   : 1 iff a < b (unsigned)
//   overflow     : signed overflow of a - b
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa, sb, sr;
    logic [CW-1:0]    cnt;
    logic             bflop;
    logic             sign_a, sign_b;

    logic             d, bout;
    logic [WIDTH-1:0] sr_nxt;
    logic             accept;

    full_subtractor_1bit u_fs (
        .x     (sa[0]),
        .y     (sb[0]),
        .b_in  (bflop),
        .d     (d),
        .b_out (bout)
    );

    // the new bit enters at the top, so after WIDTH shifts bit 0 is the LSB
    assign sr_nxt = {d, sr[WIDTH-1:1]};
    assign accept = start && (state == IDLE || state == DONE);

    // busy/done decode straight from the state flop, so start has no path to them
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            cnt        <= '0;
            bflop      <= 1'b0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else if (accept) begin
            sa     <= a;
            sb     <= b;
            sr     <= '0;
            cnt    <= '0;
            bflop  <= 1'b0;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            state  <= RUN;
        end else begin
            case (state)
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    sr    <= sr_nxt;
                    bflop <= bout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff       <= sr_nxt;
                        borrow_out <= bout;
                        // on the last bit, d is the result MSB
                        overflow   <= (sign_a != sign_b) && (d != sign_a);
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
